// File: rtl/pll_rst_ctrl_pkg.sv
// Shared definitions for the PLL reset controller: FSM state encodings,
// status counter width and the saturating increment used by the status counters.
package pll_rst_ctrl_pkg;

    // Debug-visible encodings; the numeric values are part of the block's interface.
    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Width of the lock-loss and timeout status counters.
    localparam int STAT_W = 8;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        logic [STAT_W-1:0] result;
        if (value == STAT_MAX) begin
            result = value;
        end else begin
            result = value + STAT_ONE;
        end
        return result;
    endfunction

endpackage : pll_rst_ctrl_pkg

// File: rtl/pll_rst_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// The chain clears on the synchronous reset so the FSM never sees a stale
// "locked" indication left over from before the reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through STAGES flops; the last flop is the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : sync_bit

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer. Pulses pll_rst, waits for the PLL to report lock,
// qualifies the lock for a number of consecutive cycles and only then
// releases sys_rst. Lock loss in RUN or a lock timeout restarts the sequence.
//
// Cycle counting: every state's counter measures cycles already spent in that
// state, so a state that must last N cycles leaves on the edge where its
// counter shows N-1 (WAIT_LOCK, STABLE) or N (PLL_RST, whose entry edge is
// counted as cycle 1 by loading the counter with 1). After reset the PLL_RST
// counter is 0 so that the full pulse is counted from the first edge with rst=0.
//
// Outputs: pll_rst, sys_rst and the status counters are flops updated in the
// same block as the state, so each output changes on the same edge as the
// state that implies it and nothing combinational reaches the ports.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] lock_loss_cnt,
    output logic [STAT_W-1:0] timeout_cnt
);

    // Each counter is wide enough to hold its parameter value itself.
    localparam int PULSE_W  = $clog2(PLL_RST_CYCLES) + 1;
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int WAIT_W   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

    localparam logic [PULSE_W-1:0]  PULSE_ONE   = PULSE_W'(1);
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(PLL_RST_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                locked_s;
    state_t              cur_state;
    logic [PULSE_W-1:0]  pulse_cnt;
    logic [STABLE_W-1:0] stable_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    // The only path from pll_locked into the controller.
    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Reset sequencing FSM with its cycle counters, status counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            cur_state     <= ST_PLL_RST;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            pulse_cnt     <= '0;
            stable_cnt    <= '0;
            wait_cnt      <= '0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            case (cur_state)
                // Hold the PLL in reset; lock status is meaningless here.
                ST_PLL_RST: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        cur_state <= ST_WAIT_LOCK;
                        pll_rst   <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PULSE_ONE;
                    end
                end

                // Lock wins over a timeout that expires on the same edge.
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        cur_state  <= ST_STABLE;
                        stable_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur_state   <= ST_PLL_RST;
                        pll_rst     <= 1'b1;
                        pulse_cnt   <= PULSE_ONE;
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end

                // Any synchronized low restarts qualification via WAIT_LOCK.
                ST_STABLE: begin
                    if (!locked_s) begin
                        cur_state <= ST_WAIT_LOCK;
                        wait_cnt  <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        cur_state <= ST_RUN;
                        sys_rst   <= 1'b0;
                    end else begin
                        stable_cnt <= stable_cnt + STABLE_ONE;
                    end
                end

                // System running; a lost lock resets both the PLL and the system.
                ST_RUN: begin
                    if (!locked_s) begin
                        cur_state     <= ST_PLL_RST;
                        pll_rst       <= 1'b1;
                        sys_rst       <= 1'b1;
                        pulse_cnt     <= PULSE_ONE;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end
                end

                default: begin
                    cur_state <= ST_PLL_RST;
                    pll_rst   <= 1'b1;
                    sys_rst   <= 1'b1;
                    pulse_cnt <= PULSE_ONE;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule : pll_rst_ctrl
